// File: rtl/onfi_pkg.sv
// Shared definitions for the ONFI asynchronous-interface cycle engine:
// host op encodings, engine state encoding, common ONFI opcodes and
// small op-classification helpers.
package onfi_pkg;

    // Host op encodings; 5-7 are reserved and accepted as no-ops.
    typedef enum logic [2:0] {
        OP_CMD     = 3'd0,
        OP_ADDR    = 3'd1,
        OP_DIN     = 3'd2,
        OP_DOUT    = 3'd3,
        OP_WAIT_RB = 3'd4
    } op_type_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_WB_WAIT = 3'd4,
        ST_RB_WAIT = 3'd5
    } state_e;

    // Common ONFI opcodes for upstream sequencers and benches.
    localparam logic [7:0] ONFI_READ_STATUS = 8'h70;
    localparam logic [7:0] ONFI_RESET       = 8'hFF;
    localparam logic [7:0] ONFI_READ_1ST    = 8'h00;
    localparam logic [7:0] ONFI_READ_2ND    = 8'h30;
    localparam logic [7:0] ONFI_READ_ID     = 8'h90;

    // Timing parameters of zero behave as one cycle.
    function automatic int unsigned min_one(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    // Ops that drive the IO bus and pulse WE_n.
    function automatic logic is_write_op(input logic [2:0] t);
        return (t == OP_CMD) || (t == OP_ADDR) || (t == OP_DIN);
    endfunction

    function automatic logic is_read_op(input logic [2:0] t);
        return (t == OP_DOUT);
    endfunction

endpackage

// File: rtl/onfi_sync2.sv
// Two-flop synchronizer for asynchronous ONFI inputs (e.g. RB_n).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   d_i      : asynchronous input
//   q_o      : synchronized output, RST_VAL while in reset
module onfi_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/onfi_async_cycle_engine.sv
// ONFI SDR asynchronous-interface cycle engine. Turns one host op
// (CMD, ADDR, DIN, DOUT, WAIT_RB) into one bus cycle on the ONFI pins,
// with all timing counted in clk cycles, and returns read bytes and
// ready/busy completion on a one-cycle response pulse.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   op_valid/op_ready/op_type/op_data : op request channel (no queueing)
//   rsp_valid/rsp_data/rsp_err    : response pulse (DOUT byte, WAIT_RB status)
//   busy                          : engine not idle
//   wp_en                         : host write-protect request
//   ce_n, cle, ale, we_n, re_n, wp_n, io_out, io_oe : ONFI pin drive
//   io_in, rb_n                   : ONFI pin inputs (rb_n asynchronous)
module onfi_async_cycle_engine
    import onfi_pkg::*;
#(
    parameter int unsigned T_SETUP     = 2,
    parameter int unsigned T_WP        = 3,
    parameter int unsigned T_WH        = 2,
    parameter int unsigned T_RP        = 3,
    parameter int unsigned T_REH       = 2,
    parameter int unsigned T_WB        = 4,
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned CE_IDLE     = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] op_type,
    input  logic [7:0] op_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy,
    input  logic       wp_en,
    output logic       ce_n,
    output logic       cle,
    output logic       ale,
    output logic       we_n,
    output logic       re_n,
    output logic       wp_n,
    output logic [7:0] io_out,
    output logic       io_oe,
    input  logic [7:0] io_in,
    input  logic       rb_n
);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(min_one(T_SETUP) - 1);
    localparam logic [CNT_W-1:0] WP_LAST    = CNT_W'(min_one(T_WP) - 1);
    localparam logic [CNT_W-1:0] WH_LAST    = CNT_W'(min_one(T_WH) - 1);
    localparam logic [CNT_W-1:0] RP_LAST    = CNT_W'(min_one(T_RP) - 1);
    localparam logic [CNT_W-1:0] REH_LAST   = CNT_W'(min_one(T_REH) - 1);
    localparam logic [CNT_W-1:0] WB_LAST    = CNT_W'(min_one(T_WB) - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(min_one(TIMEOUT_CYC) - 1);
    localparam logic [CNT_W-1:0] CE_LAST    = CNT_W'(min_one(CE_IDLE) - 1);
    localparam bit               WB_SKIP    = (T_WB == 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [2:0]       op_type_q, op_type_d;
    logic [7:0]       op_data_q, op_data_d;

    logic       ce_n_q, ce_n_d;
    logic       cle_q, cle_d;
    logic       ale_q, ale_d;
    logic       we_n_q, we_n_d;
    logic       re_n_q, re_n_d;
    logic       wp_n_q;
    logic [7:0] io_out_q, io_out_d;
    logic       io_oe_q, io_oe_d;
    logic       op_ready_q, op_ready_d;
    logic       busy_q, busy_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_err_q, rsp_err_d;

    logic accept;
    logic rb_sync;
    logic [CNT_W-1:0] strobe_last;
    logic [CNT_W-1:0] hold_last;

    // RB_n crosses into the clk domain before the FSM looks at it.
    onfi_sync2 #(.RST_VAL(1'b1)) u_rb_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rb_n),
        .q_o (rb_sync)
    );

    assign accept      = op_valid && op_ready_q;
    assign strobe_last = is_read_op(op_type_q) ? RP_LAST : WP_LAST;
    assign hold_last   = is_read_op(op_type_q) ? REH_LAST : WH_LAST;

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idle_cnt_q  <= '0;
            op_type_q   <= '0;
            op_data_q   <= '0;
            ce_n_q      <= 1'b1;
            cle_q       <= 1'b0;
            ale_q       <= 1'b0;
            we_n_q      <= 1'b1;
            re_n_q      <= 1'b1;
            wp_n_q      <= 1'b0;
            io_out_q    <= '0;
            io_oe_q     <= 1'b0;
            op_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            op_type_q   <= op_type_d;
            op_data_q   <= op_data_d;
            ce_n_q      <= ce_n_d;
            cle_q       <= cle_d;
            ale_q       <= ale_d;
            we_n_q      <= we_n_d;
            re_n_q      <= re_n_d;
            wp_n_q      <= ~wp_en;
            io_out_q    <= io_out_d;
            io_oe_q     <= io_oe_d;
            op_ready_q  <= op_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next state, phase counters, CE_n idle timer and pin values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idle_cnt_d  = idle_cnt_q;
        op_type_d   = op_type_q;
        op_data_d   = op_data_q;
        ce_n_d      = ce_n_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        cle_d       = 1'b0;
        ale_d       = 1'b0;
        we_n_d      = 1'b1;
        re_n_d      = 1'b1;
        io_oe_d     = 1'b0;
        io_out_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_type_d  = op_type;
                    op_data_d  = op_data;
                    cnt_d      = '0;
                    idle_cnt_d = '0;
                    ce_n_d     = 1'b0;
                    if (op_type == OP_WAIT_RB) begin
                        state_d = WB_SKIP ? ST_RB_WAIT : ST_WB_WAIT;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end else if (!ce_n_q) begin
                    // Release the chip after CE_IDLE consecutive idle cycles.
                    if (idle_cnt_q == CE_LAST) begin
                        ce_n_d     = 1'b1;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_SETUP: begin
                // Reserved ops spend exactly one cycle here with no bus activity.
                if (!is_write_op(op_type_q) && !is_read_op(op_type_q)) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == SETUP_LAST) begin
                    state_d = ST_STROBE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == strobe_last) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    // Read byte is taken on the edge where RE_n returns high.
                    if (is_read_op(op_type_q)) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = io_in;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == hold_last) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WB_WAIT: begin
                if (cnt_q == WB_LAST) begin
                    state_d = ST_RB_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RB_WAIT: begin
                // Ready wins over a timeout landing in the same cycle.
                if (rb_sync) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pins follow the state being entered so they change with it.
        if ((state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD)) begin
            cle_d   = (op_type_d == OP_CMD);
            ale_d   = (op_type_d == OP_ADDR);
            io_oe_d = is_write_op(op_type_d);
            if (is_write_op(op_type_d)) begin
                io_out_d = op_data_d;
            end
            if (state_d == ST_STROBE) begin
                we_n_d = !is_write_op(op_type_d);
                re_n_d = !is_read_op(op_type_d);
            end
        end
    end

    // Readiness and busy follow the next state; a pending response blocks acceptance.
    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        op_ready_d = (state_d == ST_IDLE) && !rsp_valid_d;
    end

    assign op_ready  = op_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign ce_n      = ce_n_q;
    assign cle       = cle_q;
    assign ale       = ale_q;
    assign we_n      = we_n_q;
    assign re_n      = re_n_q;
    assign wp_n      = wp_n_q;
    assign io_out    = io_out_q;
    assign io_oe     = io_oe_q;

endmodule

// File: tb/tb_onfi_async_cycle_engine.sv
// Self-checking bench for onfi_async_cycle_engine: directed scenarios plus
// randomized op sequences checked cycle by cycle against a phase-level model.
module tb_onfi_async_cycle_engine;
    import onfi_pkg::*;

    localparam int TS   = 2;
    localparam int TWP  = 3;
    localparam int TWH  = 2;
    localparam int TRP  = 3;
    localparam int TREH = 2;
    localparam int TWB  = 4;
    localparam int TO   = 20;
    localparam int CEI  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_type;
    logic [7:0] op_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic       wp_en;
    logic       ce_n, cle, ale, we_n, re_n, wp_n;
    logic [7:0] io_out;
    logic       io_oe;
    logic [7:0] io_in;
    logic       rb_n;

    int n_checks = 0;
    int n_errors = 0;
    int idle_run;   // consecutive idle cycles including the current one

    onfi_async_cycle_engine #(
        .T_SETUP(TS), .T_WP(TWP), .T_WH(TWH), .T_RP(TRP), .T_REH(TREH),
        .T_WB(TWB), .TIMEOUT_CYC(TO), .CE_IDLE(CEI), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type), .op_data(op_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .wp_en(wp_en),
        .ce_n(ce_n), .cle(cle), .ale(ale), .we_n(we_n), .re_n(re_n), .wp_n(wp_n),
        .io_out(io_out), .io_oe(io_oe), .io_in(io_in), .rb_n(rb_n)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {ce_n, cle, ale, we_n, re_n, io_oe, busy, op_ready, rsp_valid, rsp_err, io_out}
    function automatic logic [17:0] pins_now();
        return {ce_n, cle, ale, we_n, re_n, io_oe, busy, op_ready, rsp_valid, rsp_err, io_out};
    endfunction

    localparam logic [17:0] RESET_PINS = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

    // Bus cycles an op occupies after acceptance.
    function automatic int op_len(input logic [2:0] t);
        if (t == OP_DOUT) return TS + TRP + TREH;
        if (t <= OP_DIN)  return TS + TWP + TWH;
        return 1;
    endfunction

    // Expected pins in cycle c (1 = first cycle after the accepting edge).
    function automatic logic [17:0] exp_bus(input logic [2:0] t, input logic [7:0] b, input int c);
        bit   wr, rd, rsvd;
        int   n_str;
        logic cle_e = 1'b0, ale_e = 1'b0, we_e = 1'b1, re_e = 1'b1, oe_e = 1'b0;
        logic busy_e = 1'b0, rdy_e = 1'b1, rv_e = 1'b0;
        logic [7:0] io_e = 8'h00;
        wr    = (t == OP_CMD) || (t == OP_ADDR) || (t == OP_DIN);
        rd    = (t == OP_DOUT);
        rsvd  = !wr && !rd;
        n_str = rd ? TRP : TWP;
        if (c <= op_len(t)) begin
            busy_e = 1'b1;
            rdy_e  = 1'b0;
            if (!rsvd) begin
                cle_e = (t == OP_CMD);
                ale_e = (t == OP_ADDR);
                oe_e  = wr;
                io_e  = wr ? b : 8'h00;
                if (c > TS && c <= TS + n_str) begin
                    we_e = !wr;
                    re_e = !rd;
                end
                rv_e = rd && (c == TS + n_str + 1);
            end
        end
        return {1'b0, cle_e, ale_e, we_e, re_e, oe_e, busy_e, rdy_e, rv_e, 1'b0, io_e};
    endfunction

    task automatic accept_op(input logic [2:0] t, input logic [7:0] b);
        check_eq("accept_ready", 32'(op_ready), 32'd1);
        check_eq("accept_ce_n", 32'(ce_n), 32'(idle_run > CEI));
        op_valid = 1'b1;
        op_type  = t;
        op_data  = b;
        @(negedge clk);
        op_valid = 1'b0;
        op_type  = 3'($urandom);
        op_data  = 8'($urandom);
    endtask

    // Runs a CMD/ADDR/DIN/DOUT/reserved op through to its first idle cycle.
    task automatic run_xfer(input logic [2:0] t, input logic [7:0] b);
        int         total;
        logic [7:0] rbyte;
        total = op_len(t);
        rbyte = 8'($urandom);
        io_in = ~rbyte;
        accept_op(t, b);
        for (int c = 1; c <= total + 1; c++) begin
            check_eq($sformatf("bus_t%0d_c%0d", t, c), 32'(pins_now()), 32'(exp_bus(t, b, c)));
            if (t == OP_DOUT && c == TS + TRP + 1)
                check_eq("dout_byte", 32'(rsp_data), 32'(rbyte));
            // Only the last RE_n-low cycle presents the real byte.
            io_in = (t == OP_DOUT && c == TS + TRP) ? rbyte : ~rbyte;
            if (c <= total) @(negedge clk);
        end
        idle_run = 1;
    endtask

    // WAIT_RB with rb_n rising in cycle 'rise'; optional 1-cycle glitch in cycle 1.
    task automatic run_wait(input int rise, input bit glitch);
        int exp_c, got_c;
        bit tmo;
        rb_n = 1'b0;
        accept_op(OP_WAIT_RB, 8'h00);
        // Two synchronizer flops plus the registered response: 3 cycles.
        exp_c = (rise + 3 > TWB + 2) ? rise + 3 : TWB + 2;
        tmo   = (rise + 2 > TWB + TO);
        if (tmo) exp_c = TWB + TO + 1;
        got_c = 0;
        for (int c = 1; c <= 200 && got_c == 0; c++) begin
            if (rsp_valid === 1'b1) begin
                got_c = c;
            end else begin
                rb_n = (c >= rise) || (glitch && c == 1);
                @(negedge clk);
            end
        end
        if (got_c == 0) check_eq("wait_rb_bound", 32'(got_c), 32'(exp_c));
        check_eq("wait_rsp_cycle", 32'(got_c), 32'(exp_c));
        check_eq("wait_rsp_err", 32'(rsp_err), 32'(tmo));
        check_eq("wait_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("wait_rsp_ready_low", 32'(op_ready), 32'd0);
        @(negedge clk);
        check_eq("wait_after", 32'({rsp_valid, rsp_err, busy, op_ready, ce_n}), 32'(5'b00010));
        rb_n     = 1'b1;
        idle_run = 2;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            check_eq("gap_ce_n", 32'(ce_n), 32'(idle_run > CEI));
            check_eq("gap_ready", 32'({op_ready, busy, rsp_valid}), 32'(3'b100));
            @(negedge clk);
            idle_run++;
        end
    endtask

    initial begin
        rst      = 1'b1;
        op_valid = 1'b0;
        op_type  = 3'd0;
        op_data  = 8'h00;
        wp_en    = 1'b0;
        io_in    = 8'h00;
        rb_n     = 1'b1;
        idle_run = 100;
        repeat (3) @(negedge clk);
        check_eq("reset_pins", 32'(pins_now()), 32'(RESET_PINS));
        check_eq("reset_rsp_data", 32'(rsp_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // wp_n mirrors wp_en one cycle later.
        wp_en = 1'b1;
        @(negedge clk);
        check_eq("wp_on", 32'(wp_n), 32'd0);
        wp_en = 1'b0;
        @(negedge clk);
        check_eq("wp_off", 32'(wp_n), 32'd1);

        // READ STATUS followed immediately by a status read.
        run_xfer(OP_CMD, ONFI_READ_STATUS);
        run_xfer(OP_DOUT, 8'h00);
        idle_gap(12);

        // Five back-to-back address cycles, then CE_n release timing.
        run_xfer(OP_ADDR, 8'h00);
        run_xfer(OP_ADDR, 8'h00);
        run_xfer(OP_ADDR, 8'h12);
        run_xfer(OP_ADDR, 8'h34);
        run_xfer(OP_ADDR, 8'h01);
        idle_gap(CEI + 3);

        // Ready after a long busy, with an early glitch, and a timeout.
        run_wait(50, 1'b0);
        idle_gap(2);
        run_wait(30, 1'b1);
        run_wait(1000, 1'b0);
        idle_gap(1);

        // Reserved op is a one-cycle no-op.
        run_xfer(3'd6, 8'h55);

        // Reset in the middle of a DIN write strobe.
        accept_op(OP_DIN, 8'hA5);
        repeat (TS) @(negedge clk);
        check_eq("mid_strobe_we_n", 32'(we_n), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_pins", 32'(pins_now()), 32'(RESET_PINS));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("rst_no_rsp", 32'({rsp_valid, busy}), 32'd0);
        end
        idle_run = 100;
        run_xfer(OP_DIN, 8'hA5);

        // Randomized op mix.
        for (int k = 0; k < 40; k++) begin
            int t;
            t = $urandom_range(0, 5);
            if (t == 4) run_wait($urandom_range(3, 30), 1'($urandom));
            else if (t == 5) run_xfer(3'($urandom_range(5, 7)), 8'($urandom));
            else run_xfer(3'(t), 8'($urandom));
            if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(1, 12));
        end
        idle_gap(CEI + 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
